ofdm_demapper: RTL

Parametrised hard-decision demapper between the FFT output and the bit deinterleaver. It accepts one complex subcarrier sample per handshake and slices it as BPSK, QPSK or 16-QAM. It emits the decided bits with a bit count, subcarrier index and end-of-OFDM-symbol flag. A one-deep output register provides valid/ready backpressure. The modulation mode is latched per OFDM symbol, so it cannot change mid-symbol.

---
 rtl/ofdm_demapper.sv | 113 +++++++++++
 1 files changed

// File: rtl/ofdm_demapper.sv
// Hard-decision BPSK/QPSK/16-QAM demapper with a one-deep valid/ready output register.
// The modulation mode is latched on the first subcarrier of each OFDM symbol.
module ofdm_demapper #(
  parameter int                   DW      = 16,
  parameter int                   NSC     = 64,
  parameter int                   SCW     = (NSC > 1) ? $clog2(NSC) : 1,
  parameter logic signed [DW-1:0] QAM_THR = 16'sd4096
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           mode,
  input  logic signed [DW-1:0] inx,
  input  logic signed [DW-1:0] iny,
  input  logic                 fft_en,
  output logic                 in_ready,
  output logic                 en,
  input  logic                 out_ready,
  output logic [3:0]           out,
  output logic [2:0]           nbits,
  output logic [SCW-1:0]       sc_idx,
  output logic                 last,
  output logic                 err
);

  typedef enum logic [1:0] {
    MODE_BPSK  = 2'd0,
    MODE_QPSK  = 2'd1,
    MODE_QAM16 = 2'd2,
    MODE_RSVD  = 2'd3
  } mode_e;

  localparam logic [SCW-1:0] CNT_MAX = SCW'(NSC - 1);

  logic [SCW-1:0]       cnt;
  mode_e                mode_q;
  mode_e                mode_eff;
  logic                 accept;
  logic                 cnt_at_max;
  logic signed [DW:0]   xw, yw;
  logic [DW:0]          ax, ay;
  logic [DW:0]          thr;
  logic                 sx, sy, ix, iy;
  logic [3:0]           dec_out;
  logic [2:0]           dec_nbits;

  // in_ready must not depend on fft_en, so it is built from the output register state only.
  assign in_ready   = !en || out_ready;
  assign accept     = fft_en && in_ready;
  assign cnt_at_max = (cnt == CNT_MAX);

  // The first sample of a symbol is decided with the mode being latched alongside it.
  assign mode_eff = (cnt == '0) ? mode_e'(mode) : mode_q;

  // One extra bit of width keeps |-2^(DW-1)| representable.
  assign xw  = {inx[DW-1], inx};
  assign yw  = {iny[DW-1], iny};
  assign ax  = xw[DW] ? (DW+1)'(-xw) : (DW+1)'(xw);
  assign ay  = yw[DW] ? (DW+1)'(-yw) : (DW+1)'(yw);
  assign thr = {1'b0, QAM_THR};

  assign sx = inx[DW-1] || (inx == '0);
  assign sy = iny[DW-1] || (iny == '0);
  assign ix = (ax < thr);
  assign iy = (ay < thr);

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    dec_out   = 4'b0000;
    dec_nbits = 3'd2;
    case (mode_eff)
      MODE_BPSK: begin
        dec_out   = {3'b000, sx};
        dec_nbits = 3'd1;
      end
      MODE_QAM16: begin
        dec_out   = {sy, sx ^ sy, ix, iy};
        dec_nbits = 3'd4;
      end
      default: begin
        dec_out   = {2'b00, sy, sx ^ sy};
        dec_nbits = 3'd2;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      mode_q <= MODE_QPSK;
      err    <= 1'b0;
      en     <= 1'b0;
      out    <= 4'b0000;
      nbits  <= 3'd0;
      sc_idx <= '0;
      last   <= 1'b0;
    end else if (accept) begin
      cnt    <= cnt_at_max ? '0 : cnt + 1'b1;
      if (cnt == '0) begin
        mode_q <= mode_e'(mode);
        if (mode == MODE_RSVD) err <= 1'b1;
      end
      en     <= 1'b1;
      out    <= dec_out;
      nbits  <= dec_nbits;
      sc_idx <= cnt;
      last   <= cnt_at_max;
    end else if (en && out_ready) begin
      en <= 1'b0;
    end
  end

endmodule
